// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative write-back cache.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        FILL,
        FLUSH_SCAN,
        FLUSH_WB
    } cache_state_t;

    function automatic int line_w(input int s_offset);
        return 8 * (1 << s_offset);
    endfunction

    function automatic int num_ways(input int s_wayidx);
        return 1 << s_wayidx;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU: next tree state for an access and the current victim way.
module plru_tree #(
    parameter int S_WAYIDX = 2
) (
    input  logic [(2**S_WAYIDX)-1:1] i_tree,
    input  logic [S_WAYIDX-1:0]      i_way,
    output logic [(2**S_WAYIDX)-1:1] o_tree,
    output logic [S_WAYIDX-1:0]      o_victim
);

    logic [S_WAYIDX:0] w_vnode;
    logic [S_WAYIDX:0] w_unode;

    // Follow the tree bits from the root; the leaf reached is NUM_WAYS + victim.
    always_comb begin
        w_vnode = (S_WAYIDX+1)'(1);
        for (int l = 0; l < S_WAYIDX; l++)
            w_vnode = {w_vnode[S_WAYIDX-1:0], i_tree[w_vnode[S_WAYIDX-1:0]]};
        o_victim = w_vnode[S_WAYIDX-1:0];
    end

    // Nodes on the path to the accessed way are turned to point away from it.
    always_comb begin
        o_tree  = i_tree;
        w_unode = '0;
        for (int l = 0; l < S_WAYIDX; l++) begin
            w_unode = {1'b1, i_way} >> (S_WAYIDX - l);
            o_tree[w_unode[S_WAYIDX-1:0]] = ~i_way[S_WAYIDX-1-l];
        end
    end

endmodule

// File: rtl/plru_wb_cache.sv
// N-way set-associative write-back/write-allocate cache with tree-PLRU and flush.
module plru_wb_cache
    import cache_pkg::*;
#(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 4,
    parameter int S_WAYIDX = 2,
    parameter int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  mem_address,
    input  logic                         mem_read,
    input  logic                         mem_write,
    input  logic [(2**S_OFFSET)-1:0]     mem_byte_enable,
    input  logic [8*(2**S_OFFSET)-1:0]   mem_wdata,
    output logic [8*(2**S_OFFSET)-1:0]   mem_rdata,
    output logic                         mem_resp,
    input  logic                         flush_req,
    output logic                         flush_done,
    output logic [31:0]                  pmem_address,
    output logic                         pmem_read,
    output logic                         pmem_write,
    output logic [8*(2**S_OFFSET)-1:0]   pmem_wdata,
    input  logic [8*(2**S_OFFSET)-1:0]   pmem_rdata,
    input  logic                         pmem_resp
);

    localparam int LINE_W   = line_w(S_OFFSET);
    localparam int NUM_WAYS = num_ways(S_WAYIDX);
    localparam int NUM_SETS = 2**S_INDEX;
    localparam int NBYTES   = 2**S_OFFSET;
    localparam int CNT_W    = S_INDEX + S_WAYIDX;

    cache_state_t r_state, w_state_n;

    logic [LINE_W-1:0]   r_data  [NUM_SETS][NUM_WAYS];
    logic [S_TAG-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
    logic [NUM_WAYS-1:0] r_dirty [NUM_SETS];
    logic [NUM_WAYS-1:1] r_plru  [NUM_SETS];

    logic [31-S_OFFSET:0] r_line;
    logic                 r_we;
    logic [LINE_W-1:0]    r_wdata;
    logic [NBYTES-1:0]    r_be;
    logic [S_WAYIDX-1:0]  r_victim;
    logic [CNT_W-1:0]     r_fl_cnt;

    logic [S_INDEX-1:0]   w_idx;
    logic [S_TAG-1:0]     w_tag;
    logic                 w_hit, w_inv_found;
    logic [S_WAYIDX-1:0]  w_hitway, w_inv_way, w_plru_victim, w_victim;
    logic [NUM_WAYS-1:1]  w_plru_next;
    logic [S_INDEX-1:0]   w_fl_set;
    logic [S_WAYIDX-1:0]  w_fl_way;
    logic                 w_fl_last;
    logic                 w_ld_req, w_hit_upd, w_ld_vict, w_fill;
    logic                 w_fl_clr, w_fl_inc, w_fl_clean;
    logic                 w_unused_offset;

    assign w_unused_offset = ^mem_address[S_OFFSET-1:0];
    assign w_idx     = r_line[S_INDEX-1:0];
    assign w_tag     = r_line[31-S_OFFSET -: S_TAG];
    assign w_fl_set  = r_fl_cnt[CNT_W-1 -: S_INDEX];
    assign w_fl_way  = r_fl_cnt[S_WAYIDX-1:0];
    assign w_fl_last = &r_fl_cnt;
    assign w_victim  = w_inv_found ? w_inv_way : w_plru_victim;

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hitway    = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = S_WAYIDX'(w);
            end
            if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
                w_hit    = 1'b1;
                w_hitway = S_WAYIDX'(w);
            end
        end
    end

    plru_tree #(.S_WAYIDX(S_WAYIDX)) u_plru (
        .i_tree   (r_plru[w_idx]),
        .i_way    (w_hitway),
        .o_tree   (w_plru_next),
        .o_victim (w_plru_victim)
    );

    always_comb begin
        w_state_n    = r_state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        flush_done   = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        w_ld_req     = 1'b0;
        w_hit_upd    = 1'b0;
        w_ld_vict    = 1'b0;
        w_fill       = 1'b0;
        w_fl_clr     = 1'b0;
        w_fl_inc     = 1'b0;
        w_fl_clean   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    w_ld_req  = 1'b1;
                    w_state_n = CHECK;
                end else if (flush_req) begin
                    w_fl_clr  = 1'b1;
                    w_state_n = FLUSH_SCAN;
                end
            end
            CHECK: begin
                if (w_hit) begin
                    mem_resp  = 1'b1;
                    mem_rdata = r_data[w_idx][w_hitway];
                    w_hit_upd = 1'b1;
                    w_state_n = IDLE;
                end else begin
                    w_ld_vict = 1'b1;
                    w_state_n = (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim])
                                ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[w_idx][r_victim], w_idx, {S_OFFSET{1'b0}}};
                pmem_wdata   = r_data[w_idx][r_victim];
                if (pmem_resp) w_state_n = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {w_tag, w_idx, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    w_fill    = 1'b1;
                    w_state_n = CHECK;
                end
            end
            FLUSH_SCAN: begin
                if (r_valid[w_fl_set][w_fl_way] && r_dirty[w_fl_set][w_fl_way]) begin
                    w_state_n = FLUSH_WB;
                end else if (w_fl_last) begin
                    flush_done = 1'b1;
                    w_state_n  = IDLE;
                end else begin
                    w_fl_inc = 1'b1;
                end
            end
            FLUSH_WB: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[w_fl_set][w_fl_way], w_fl_set, {S_OFFSET{1'b0}}};
                pmem_wdata   = r_data[w_fl_set][w_fl_way];
                if (pmem_resp) begin
                    w_fl_clean = 1'b1;
                    if (w_fl_last) begin
                        flush_done = 1'b1;
                        w_state_n  = IDLE;
                    end else begin
                        w_fl_inc  = 1'b1;
                        w_state_n = FLUSH_SCAN;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            r_state <= w_state_n;
            if (w_hit_upd) begin
                r_plru[w_idx] <= w_plru_next;
                if (r_we) r_dirty[w_idx][w_hitway] <= 1'b1;
            end
            if (w_fill) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= 1'b0;
            end
            if (w_fl_clean) r_dirty[w_fl_set][w_fl_way] <= 1'b0;
        end
    end

    // Payload storage carries no reset; validity alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (w_ld_req) begin
            r_line  <= mem_address[31:S_OFFSET];
            r_we    <= mem_write;
            r_wdata <= mem_wdata;
            r_be    <= mem_byte_enable;
        end
        if (w_ld_vict) r_victim <= w_victim;
        if (w_fl_clr)      r_fl_cnt <= '0;
        else if (w_fl_inc) r_fl_cnt <= r_fl_cnt + 1'b1;
        if (w_fill) begin
            r_data[w_idx][r_victim] <= pmem_rdata;
            r_tag[w_idx][r_victim]  <= w_tag;
        end
        if (w_hit_upd && r_we) begin
            for (int b = 0; b < NBYTES; b++)
                if (r_be[b]) r_data[w_idx][w_hitway][8*b +: 8] <= r_wdata[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_plru_wb_cache.sv
// Randomized bench for plru_wb_cache against a line-level cache/memory model.
module tb_plru_wb_cache;

    localparam int LW = 256;
    localparam int NW = 4;
    localparam int NS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   mem_address = '0;
    logic          mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0]   mem_byte_enable = '0;
    logic [LW-1:0] mem_wdata = '0, mem_rdata;
    logic          mem_resp;
    logic          flush_req = 1'b0, flush_done;
    logic [31:0]   pmem_address;
    logic          pmem_read, pmem_write;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    plru_wb_cache dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .flush_req(flush_req), .flush_done(flush_done),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] pat(input bit [31:0] a);
        logic [LW-1:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = a ^ (32'h0101_0101 * (i + 1)) ^ 32'hC0DE_0000;
        return r;
    endfunction

    // Behavioural model: per-set way arrays, PLRU tree bits at heap nodes 1..3, backing memory.
    bit            m_valid [NS][NW];
    bit            m_dirty [NS][NW];
    bit [31:0]     m_tag   [NS][NW];
    logic [LW-1:0] m_data  [NS][NW];
    bit            m_plru  [NS][NW];
    logic [LW-1:0] m_mem   [bit [31:0]];
    logic [LW-1:0] r_mem   [bit [31:0]];

    typedef struct { bit wr; bit [31:0] addr; logic [LW-1:0] data; } px_t;
    px_t       exp_q[$];
    bit [31:0] rd_log[$];
    bit [31:0] wb_log[$];
    logic [LW-1:0] last_rdata;

    function automatic logic [LW-1:0] mline(input bit [31:0] a);
        return m_mem.exists(a) ? m_mem[a] : pat(a);
    endfunction

    function automatic logic [LW-1:0] rline(input bit [31:0] a);
        return r_mem.exists(a) ? r_mem[a] : pat(a);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 0; m_dirty[s][w] = 0; m_plru[s][w] = 0;
            end
    endtask

    task automatic model_access(input bit wr, input bit [31:0] a, input bit [31:0] be,
                                input logic [LW-1:0] wd, output logic [LW-1:0] rd, output bit hit);
        int s, w, node, d;
        bit [31:0] tg, fa, va;
        px_t e;
        s = int'((a >> 5) & 15); tg = a >> 9; fa = a & ~32'd31; w = -1;
        for (int i = 0; i < NW; i++) if (m_valid[s][i] && m_tag[s][i] == tg) w = i;
        hit = (w >= 0);
        if (!hit) begin
            for (int i = NW - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
            if (w < 0) begin
                node = 1;
                while (node < NW) node = 2 * node + int'(m_plru[s][node]);
                w = node - NW;
            end
            if (m_valid[s][w] && m_dirty[s][w]) begin
                va = (m_tag[s][w] << 9) | (s << 5);
                e.wr = 1; e.addr = va; e.data = m_data[s][w];
                exp_q.push_back(e);
                m_mem[va] = m_data[s][w];
            end
            e.wr = 0; e.addr = fa; e.data = '0;
            exp_q.push_back(e);
            m_data[s][w] = mline(fa); m_tag[s][w] = tg; m_valid[s][w] = 1; m_dirty[s][w] = 0;
        end
        rd = m_data[s][w];
        if (wr) begin
            for (int b = 0; b < 32; b++) if (be[b]) m_data[s][w][8*b +: 8] = wd[8*b +: 8];
            m_dirty[s][w] = 1;
        end
        node = 1;
        for (int l = 0; l < 2; l++) begin
            d = (w >> (1 - l)) & 1;
            m_plru[s][node] = (d == 0);
            node = 2 * node + d;
        end
    endtask

    task automatic model_flush();
        px_t e;
        bit [31:0] va;
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++)
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    va = (m_tag[s][w] << 9) | (s << 5);
                    e.wr = 1; e.addr = va; e.data = m_data[s][w];
                    exp_q.push_back(e);
                    m_mem[va] = m_data[s][w];
                    m_dirty[s][w] = 0;
                end
    endtask

    // Memory responder and per-cycle compare of pmem traffic against the model's expectations.
    bit  busy = 0, hold_resp = 0;
    int  dly = 0;
    px_t pe;
    always @(negedge clk) begin
        chk("pmem_rd_wr_excl", LW'(pmem_read && pmem_write), '0);
        chk("resp_done_excl", LW'(mem_resp && flush_done), '0);
        if (pmem_resp) begin
            pmem_resp = 1'b0;
        end else if (!rst && (pmem_read || pmem_write)) begin
            if (!busy) begin
                busy = 1; dly = $urandom_range(0, 3);
                if (exp_q.size() == 0) chk("pmem_unexpected", LW'(1), '0);
                else begin
                    pe = exp_q.pop_front();
                    chk("pmem_kind", LW'(pmem_write), LW'(pe.wr));
                    chk("pmem_addr", LW'(pmem_address), LW'(pe.addr));
                    if (pe.wr) chk("pmem_wdata", pmem_wdata, pe.data);
                end
                if (pmem_write) begin
                    wb_log.push_back(pmem_address);
                    r_mem[pmem_address] = pmem_wdata;
                end else rd_log.push_back(pmem_address);
            end
            if (!hold_resp) begin
                if (dly == 0) begin
                    pmem_rdata = pmem_read ? rline(pmem_address) : '0;
                    pmem_resp  = 1'b1;
                    busy       = 0;
                end else dly--;
            end
        end else busy = 0;
    end

    task automatic cpu_op(input bit wr, input bit [31:0] a, input bit [31:0] be, input logic [LW-1:0] wd);
        logic [LW-1:0] er;
        bit eh;
        int cyc;
        model_access(wr, a, be, wd, er, eh);
        mem_address = a; mem_read = !wr; mem_write = wr; mem_byte_enable = be; mem_wdata = wd;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (mem_resp) break;
            if (eh) chk("hit_no_pmem", LW'(pmem_read | pmem_write), '0);
            cyc++;
            if (cyc > 300) break;
        end
        if (!mem_resp) chk("resp_timeout", '0, LW'(1));
        else begin
            last_rdata = mem_rdata;
            chk("rdata", mem_rdata, er);
            if (eh) chk("hit_latency", LW'(cyc), LW'(1));
        end
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0;
        chk("exp_q_drained", LW'(exp_q.size()), '0);
    endtask

    task automatic do_flush(output int cyc);
        model_flush();
        flush_req = 1; cyc = 0;
        forever begin
            @(negedge clk);
            if (flush_done) break;
            cyc++;
            if (cyc > 3000) break;
        end
        if (!flush_done) chk("flush_timeout", '0, LW'(1));
        @(posedge clk); #1;
        flush_req = 0;
        chk("flush_q_drained", LW'(exp_q.size()), '0);
    endtask

    initial begin
        logic [LW-1:0] t, wd;
        int fc, k;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_resp", LW'(mem_resp), '0);
        chk("rst_pmem_read", LW'(pmem_read), '0);
        chk("rst_pmem_write", LW'(pmem_write), '0);
        chk("rst_flush_done", LW'(flush_done), '0);
        chk("rst_pmem_addr", LW'(pmem_address), '0);
        @(posedge clk); #1 rst = 0;

        // Cold read, then repeat hit.
        rd_log.delete();
        cpu_op(0, 32'h0000_1040, '0, '0);
        chk("cold_fill_cnt", LW'(rd_log.size()), LW'(1));
        chk("cold_fill_addr", LW'(rd_log[0]), LW'(32'h0000_1040));
        chk("cold_rdata", last_rdata, pat(32'h0000_1040));
        cpu_op(0, 32'h0000_1040, '0, '0);

        // Byte-masked write to the resident line.
        wd = '1; wd[31:0] = 32'hDEAD_BEEF;
        cpu_op(1, 32'h0000_1040, 32'h0000_000F, wd);
        cpu_op(0, 32'h0000_1040, '0, '0);
        t = pat(32'h0000_1040); t[31:0] = 32'hDEAD_BEEF;
        chk("merged_rdata", last_rdata, t);

        // Set 3: fill tags 1..4, dirty tag 1, touch 2,3 -> tag 5 evicts tag 1's way.
        for (int i = 1; i <= 4; i++) cpu_op(0, (i << 9) | 32'h60, '0, '0);
        cpu_op(1, 32'h0000_0260, 32'h1, '1);
        cpu_op(0, 32'h0000_0460, '0, '0);
        cpu_op(0, 32'h0000_0660, '0, '0);
        rd_log.delete(); wb_log.delete();
        cpu_op(0, 32'h0000_0A60, '0, '0);
        chk("plru_wb_cnt", LW'(wb_log.size()), LW'(1));
        chk("plru_wb_addr", LW'(wb_log[0]), LW'(32'h0000_0260));
        chk("plru_fill_addr", LW'(rd_log[0]), LW'(32'h0000_0A60));

        // Set 4: invalid way preferred, no writeback.
        cpu_op(0, 32'h0000_0280, '0, '0);
        cpu_op(0, 32'h0000_0480, '0, '0);
        rd_log.delete(); wb_log.delete();
        cpu_op(0, 32'h0000_0680, '0, '0);
        chk("inv_first_no_wb", LW'(wb_log.size()), '0);
        chk("inv_first_fill", LW'(rd_log[0]), LW'(32'h0000_0680));

        // Reset during a fill.
        do_flush(fc);
        begin
            logic [LW-1:0] dr;
            bit dh;
            model_access(0, 32'h7000_0000, '0, '0, dr, dh);
        end
        hold_resp = 1;
        mem_address = 32'h7000_0000; mem_read = 1;
        k = 0;
        do begin @(negedge clk); k++; end while (!pmem_read && k < 20);
        chk("rst_fill_seen", LW'(pmem_read), LW'(1));
        @(posedge clk); #1 rst = 1; mem_read = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_abort_pmem_read", LW'(pmem_read), '0);
        chk("rst_abort_pmem_write", LW'(pmem_write), '0);
        @(posedge clk); #1 rst = 0;
        model_reset(); exp_q.delete(); hold_resp = 0;
        rd_log.delete();
        cpu_op(0, 32'h7000_0000, '0, '0);
        chk("post_rst_miss", LW'(rd_log.size()), LW'(1));

        // Random traffic over a small conflict-heavy address pool.
        for (int n = 0; n < 300; n++) begin
            int r, st;
            bit [31:0] a;
            r = $urandom_range(0, 99);
            if (r < 4) do_flush(fc);
            else begin
                case ($urandom_range(0, 3))
                    0: st = 0; 1: st = 1; 2: st = 2; default: st = 15;
                endcase
                a = ($urandom_range(0, 5) << 9) | (st << 5) | $urandom_range(0, 31);
                for (int i = 0; i < 8; i++) wd[32*i +: 32] = $urandom();
                cpu_op(r < 50, a, $urandom(), wd);
            end
        end

        // Flush with dirty lines only in sets 0 and 15, then a clean flush.
        do_flush(fc);
        cpu_op(1, 32'h0000_0000, 32'hFFFF_FFFF, '1);
        cpu_op(1, 32'h0000_01E0, 32'h0000_00F0, '0);
        wb_log.delete();
        do_flush(fc);
        chk("flush_wb_cnt", LW'(wb_log.size()), LW'(2));
        chk("flush_wb0", LW'(wb_log[0]), LW'(32'h0000_0000));
        chk("flush_wb1", LW'(wb_log[1]), LW'(32'h0000_01E0));
        wb_log.delete();
        do_flush(fc);
        chk("clean_flush_wb", LW'(wb_log.size()), '0);
        chk("clean_flush_cycles", LW'(fc), LW'(64));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
